// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC issue to imem, credit-based response FIFO, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN: a response into an empty queue reaches decode in the same cycle.
module fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        inst_valid_d,
  output logic [31:0] inst_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   r_fetch_pc;
  logic [OW-1:0] r_out;
  logic [OW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [IW-1:0] r_if_wr;
  logic [IW-1:0] r_if_rd;
  logic [31:0]   r_if_pc   [MAX_OUTSTANDING];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_inst  [DEPTH];

  logic          w_req_valid;
  logic          w_hs;
  logic          w_rsp;
  logic          w_rsp_drop;
  logic          w_rsp_keep;
  logic          w_byp;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_rsp_pc;
  logic [OW-1:0] w_out_after_rsp;

  function automatic logic [IW-1:0] f_if_inc(input logic [IW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + IW'(1);
  endfunction

  // Credit check counts in-flight requests so every accepted request already owns a FIFO slot.
  assign w_req_valid = rst && !redirect && (32'(r_out) < MAX_OUTSTANDING) &&
                       ((32'(r_count) + 32'(r_out)) < DEPTH);
  assign w_hs        = w_req_valid && imem_req_ready;

  assign w_rsp           = imem_rsp_valid && (r_out != '0);
  assign w_rsp_drop      = w_rsp && (redirect || (r_drop != '0));
  assign w_rsp_keep      = w_rsp && !w_rsp_drop;
  assign w_rsp_pc        = r_if_pc[r_if_rd];
  assign w_out_after_rsp = r_out - OW'(w_rsp);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_rsp_keep && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_pop  = (r_count != '0) && !stall_d && !redirect;
  assign w_push = w_rsp_keep && !(w_byp && !stall_d);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign empty          = (r_count == '0);
  assign inst_valid_d   = (r_count != '0) || w_byp;

  always_comb begin
    inst_d = '0;
    pc_d   = '0;
    if (r_count != '0) begin
      inst_d = r_q_inst[r_rd];
      pc_d   = r_q_pc[r_rd];
    end else if (w_byp) begin
      inst_d = imem_rsp_data;
      pc_d   = w_rsp_pc;
    end
  end

  assign pc_plus4_d = inst_valid_d ? (pc_d + 32'd4) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_if_wr    <= '0;
      r_if_rd    <= '0;
    end else if (redirect) begin
      // No handshake is possible this cycle, so whatever is still unreturned must be squashed.
      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      r_out      <= w_out_after_rsp;
      r_drop     <= w_out_after_rsp;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      if (w_rsp) r_if_rd <= f_if_inc(r_if_rd);
    end else begin
      if (w_hs) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_if_wr    <= f_if_inc(r_if_wr);
      end
      if (w_rsp)      r_if_rd <= f_if_inc(r_if_rd);
      if (w_rsp_drop) r_drop  <= r_drop - OW'(1);
      if (w_push)     r_wr    <= r_wr + AW'(1);
      if (w_pop)      r_rd    <= r_rd + AW'(1);
      r_out   <= r_out + OW'(w_hs) - OW'(w_rsp);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_if_pc[r_if_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_wr]   <= w_rsp_pc;
      r_q_inst[r_wr] <= imem_rsp_data;
    end
  end

endmodule
